instr_encoder: RTL and testbench

// - Inverse of the immediate decode stage: packs {opcode, rd, rs1, rs2, imm} fields into 16-bit instruction words.
// - Range-checks each immediate against its encoding.
// - Streams accepted words with sequential load addresses into instruction memory; used by the boot/program loader.
// - Single-entry output register with valid/ready handshake on both sides.

---
 rtl/instr_encoder.sv | 128 ++++++++++++
 tb/tb_instr_encoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Packs opcode/register/immediate fields into 16-bit instruction words and streams them out
// with sequential load addresses. Define ENC_IMM_SAT_EN to clamp out-of-range immediates.
module instr_encoder #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        op,
    input  logic [2:0]        rd,
    input  logic [2:0]        rs1,
    input  logic [2:0]        rs2,
    input  logic [WIDTH-1:0]  imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err,
    input  logic              err_clr
);

    // Opcode values shared with the decode stage.
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_SLLI = 4'h2;
    localparam logic [3:0] OP_SRLI = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_BLT  = 4'h5;
    localparam logic [3:0] OP_J    = 4'h6;

    typedef enum logic [0:0] {StRun, StErr} state_e;

    state_e            state;
    logic [ADDR_W-1:0] cnt;
    logic              accept;
    logic              fire;
    logic              imm_bad;
    logic              drop;
    logic [11:0]       imm_eff;
    logic [WIDTH-1:0]  enc;

    assign in_ready = (state == StRun) && (!out_valid || out_ready) && !reset;
    assign accept   = in_valid && in_ready;
    assign fire     = out_valid && out_ready;

    // Range check; imm_eff carries the clamped value used when saturation is enabled.
    always_comb begin
        imm_bad = 1'b0;
        imm_eff = imm[11:0];
        case (op)
            OP_ADDI, OP_BEQ, OP_BLT: begin
                if ($signed(imm) < -16'sd32) begin
                    imm_bad = 1'b1;
                    imm_eff = 12'hFE0;
                end else if ($signed(imm) > 16'sd31) begin
                    imm_bad = 1'b1;
                    imm_eff = 12'h01F;
                end
            end
            OP_SLLI, OP_SRLI: begin
                if (imm > 16'd15) begin
                    imm_bad = 1'b1;
                    imm_eff = 12'h00F;
                end
            end
            OP_J: begin
                if ($signed(imm) < -16'sd2048) begin
                    imm_bad = 1'b1;
                    imm_eff = 12'h800;
                end else if ($signed(imm) > 16'sd2047) begin
                    imm_bad = 1'b1;
                    imm_eff = 12'h7FF;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        case (op)
            OP_ADDI, OP_SLLI, OP_SRLI: enc = {op, rd, imm_eff[5:0], rs1};
            OP_BEQ, OP_BLT:            enc = {op, rs1, rs2, imm_eff[5:0]};
            OP_J:                      enc = {op, imm_eff};
            default:                   enc = {op, rd, rs1, rs2, 3'b000};
        endcase
    end

`ifdef ENC_IMM_SAT_EN
    assign drop = 1'b0;
`else
    assign drop = imm_bad;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= StRun;
            out_valid <= 1'b0;
            out_instr <= '0;
            out_addr  <= '0;
            cnt       <= '0;
            err       <= 1'b0;
        end else begin
            if (fire) begin
                cnt       <= cnt + 1'b1;
                out_valid <= 1'b0;
            end
            if (accept && !drop) begin
                out_valid <= 1'b1;
                out_instr <= enc;
                // The word leaving this cycle has already consumed cnt.
                out_addr  <= fire ? cnt + 1'b1 : cnt;
            end
`ifdef ENC_IMM_SAT_EN
            err <= accept && imm_bad;
`else
            if (accept && imm_bad) begin
                err   <= 1'b1;
                state <= StErr;
            end else if (err_clr && state == StErr) begin
                err   <= 1'b0;
                state <= StRun;
            end
`endif
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus randomized traffic scored
// against a field-arithmetic reference model and an in-order word queue.
module tb_instr_encoder;

    localparam logic [3:0] OP_ADDI = 4'd1;
    localparam logic [3:0] OP_SLLI = 4'd2;
    localparam logic [3:0] OP_SRLI = 4'd3;
    localparam logic [3:0] OP_BEQ  = 4'd4;
    localparam logic [3:0] OP_BLT  = 4'd5;
    localparam logic [3:0] OP_J    = 4'd6;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [2:0]  rd = '0;
    logic [2:0]  rs1 = '0;
    logic [2:0]  rs2 = '0;
    logic [15:0] imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_instr;
    logic [7:0]  out_addr;
    logic        err;
    logic        err_clr = 1'b0;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [23:0] q[$];          // {addr, instr} of words accepted but not yet fired
    int          naddr = 0;
    bit          err_m = 1'b0;

    always #5 clk = ~clk;

    instr_encoder #(.WIDTH(16), .ADDR_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_addr  (out_addr),
        .err       (err),
        .err_clr   (err_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    function automatic logic [15:0] ref_enc(input logic [3:0] o, input logic [2:0] d,
                                            input logic [2:0] s1, input logic [2:0] s2,
                                            input logic [15:0] im, output bit bad);
        int v, lo, hi, f6, f12, w, oi;
        oi  = int'(o);
        v   = int'($signed(im));
        lo  = -100000;
        hi  = 100000;
        if (o == OP_ADDI || o == OP_BEQ || o == OP_BLT) begin
            lo = -32;
            hi = 31;
        end else if (o == OP_SLLI || o == OP_SRLI) begin
            v  = int'({16'd0, im});
            lo = 0;
            hi = 15;
        end else if (o == OP_J) begin
            lo = -2048;
            hi = 2047;
        end
        bad = (v < lo) || (v > hi);
        if (v < lo) v = lo;
        if (v > hi) v = hi;
        f6  = ((v % 64) + 64) % 64;
        f12 = ((v % 4096) + 4096) % 4096;
        if (o == OP_ADDI || o == OP_SLLI || o == OP_SRLI)
            w = oi * 4096 + int'(d) * 512 + f6 * 8 + int'(s1);
        else if (o == OP_BEQ || o == OP_BLT)
            w = oi * 4096 + int'(s1) * 512 + int'(s2) * 64 + f6;
        else if (o == OP_J)
            w = oi * 4096 + f12;
        else
            w = oi * 4096 + int'(d) * 512 + int'(s1) * 64 + int'(s2) * 8;
        return w[15:0];
    endfunction

    // Drive one cycle of inputs, score outputs at the negedge, then advance the model.
    task automatic step(input bit v, input logic [3:0] o, input logic [2:0] d,
                        input logic [2:0] s1, input logic [2:0] s2, input logic [15:0] im,
                        input bit ordy, input bit clr);
        bit          rdy, fire, acc, bad;
        logic [15:0] w;
        in_valid  = v;
        op        = o;
        rd        = d;
        rs1       = s1;
        rs2       = s2;
        imm       = im;
        out_ready = ordy;
        err_clr   = clr;
        @(negedge clk);
        if (reset) begin
            check_eq("in_ready_rst", 32'(in_ready), 32'd0);
            q.delete();
            naddr = 0;
            err_m = 1'b0;
        end else begin
`ifdef ENC_IMM_SAT_EN
            rdy = (q.size() == 0) || out_ready;
`else
            rdy = !err_m && ((q.size() == 0) || out_ready);
`endif
            check_eq("out_valid", 32'(out_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                check_eq("out_instr", 32'(out_instr), 32'(q[0][15:0]));
                check_eq("out_addr", 32'(out_addr), 32'(q[0][23:16]));
            end
            check_eq("err", 32'(err), 32'(err_m));
            check_eq("in_ready", 32'(in_ready), 32'(rdy));
            fire = (q.size() != 0) && out_ready;
            acc  = in_valid && rdy;
            bad  = 1'b0;
            if (fire) void'(q.pop_front());
            if (acc) begin
                w = ref_enc(op, rd, rs1, rs2, imm, bad);
`ifdef ENC_IMM_SAT_EN
                q.push_back({8'(naddr), w});
                naddr = (naddr + 1) % 256;
`else
                if (!bad) begin
                    q.push_back({8'(naddr), w});
                    naddr = (naddr + 1) % 256;
                end
`endif
            end
`ifdef ENC_IMM_SAT_EN
            err_m = acc && bad;
`else
            if (acc && bad) err_m = 1'b1;
            else if (err_clr && err_m) err_m = 1'b0;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit ordy);
        step(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'd0, ordy, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1'b0);
        idle(1'b0);
        reset = 1'b0;
    endtask

    initial begin
        logic [3:0]  ro;
        logic [15:0] ri;

        do_reset();
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_instr", 32'(out_instr), 32'd0);
        check_eq("rst_out_addr", 32'(out_addr), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);

        // ADDI rd=2 rs1=1 imm=-3
        step(1'b1, OP_ADDI, 3'd2, 3'd1, 3'd0, -16'sd3, 1'b1, 1'b0);
        check_eq("addi_word", 32'(out_instr), 32'h15E9);
        check_eq("addi_addr", 32'(out_addr), 32'd0);

        // J 2047 then BEQ back-to-back
        do_reset();
        step(1'b1, OP_J, 3'd0, 3'd0, 3'd0, 16'd2047, 1'b1, 1'b0);
        check_eq("j_word", 32'(out_instr), 32'h67FF);
        check_eq("j_addr", 32'(out_addr), 32'd0);
        step(1'b1, OP_BEQ, 3'd0, 3'd1, 3'd2, 16'd5, 1'b1, 1'b0);
        check_eq("beq_word", 32'(out_instr), 32'h4285);
        check_eq("beq_addr", 32'(out_addr), 32'd1);
        check_eq("beq_valid", 32'(out_valid), 32'd1);

        // Backpressure with a held word
        for (int i = 0; i < 4; i++) step(1'b1, OP_ADDI, 3'd1, 3'd1, 3'd0, 16'd7, 1'b0, 1'b0);
        check_eq("hold_in_ready", 32'(in_ready), 32'd0);
        check_eq("hold_addr", 32'(out_addr), 32'd1);
        idle(1'b1);
        check_eq("drain_valid", 32'(out_valid), 32'd0);
        step(1'b1, OP_ADDI, 3'd1, 3'd1, 3'd0, 16'd7, 1'b1, 1'b0);
        check_eq("after_hold_addr", 32'(out_addr), 32'd2);

`ifdef ENC_IMM_SAT_EN
        do_reset();
        step(1'b1, OP_SLLI, 3'd1, 3'd2, 3'd0, 16'd20, 1'b1, 1'b0);
        check_eq("sat_slli_word", 32'(out_instr), 32'h227A);
        check_eq("sat_err_pulse", 32'(err), 32'd1);
        step(1'b1, OP_BLT, 3'd0, 3'd3, 3'd4, -16'sd100, 1'b1, 1'b0);
        check_eq("sat_blt_word", 32'(out_instr), 32'h5720);
        idle(1'b1);
        check_eq("sat_err_low", 32'(err), 32'd0);
`else
        do_reset();
        step(1'b1, OP_ADDI, 3'd1, 3'd1, 3'd0, 16'd40, 1'b1, 1'b0);
        check_eq("oor_valid", 32'(out_valid), 32'd0);
        check_eq("oor_err", 32'(err), 32'd1);
        check_eq("oor_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, OP_ADDI, 3'd1, 3'd1, 3'd0, 16'd1, 1'b1, 1'b0);
        step(1'b0, 4'd0, 3'd0, 3'd0, 3'd0, 16'd0, 1'b1, 1'b1);
        check_eq("clr_err", 32'(err), 32'd0);
        step(1'b1, OP_ADDI, 3'd3, 3'd4, 3'd0, 16'd1, 1'b1, 1'b0);
        check_eq("clr_word", 32'(out_instr), 32'h160C);
        check_eq("clr_addr", 32'(out_addr), 32'd0);
`endif

        // Counter wrap, then reset while a word is held
        do_reset();
        for (int i = 0; i < 257; i++)
            step(1'b1, OP_ADDI, 3'(i), 3'(i + 1), 3'd0, 16'(i % 32), 1'b1, 1'b0);
        check_eq("wrap_addr", 32'(out_addr), 32'd0);
        check_eq("wrap_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        idle(1'b0);
        reset = 1'b0;
        check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mid_addr", 32'(out_addr), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ro = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 6)) : 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       ri = 16'($urandom_range(0, 80)) - 16'd40;
                1:       ri = 16'($urandom_range(0, 20));
                2:       ri = 16'($urandom_range(0, 4200)) - 16'd2100;
                default: ri = 16'($urandom);
            endcase
            reset = ($urandom_range(0, 299) == 0);
            step(($urandom_range(0, 3) != 0), ro, 3'($urandom), 3'($urandom), 3'($urandom),
                 ri, ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0));
        end
        reset = 1'b0;
        idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
